// File: rtl/game_pkg.sv
// Shared encodings for the tic-tac-toe turn controller and its display/score neighbours.
// Holds mark and game_state codes plus the table of the eight winning lines.
package game_pkg;

    localparam logic [1:0] MARK_X    = 2'b10;
    localparam logic [1:0] MARK_O    = 2'b01;
    localparam logic [1:0] MARK_NONE = 2'b00;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_BUSY = 2'b10;
    localparam logic [1:0] GS_OVER = 2'b11;

    // Rows, columns, then both diagonals; cell order inside a line is irrelevant.
    localparam logic [7:0][2:0][3:0] WIN_LINES = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/line_checker.sv
// Combinational three-in-a-row detector for one player's mark over the 3x3 grid.
// An empty mark never reports a hit, so an all-empty line cannot count as a win.
module line_checker
    import game_pkg::*;
(
    input  logic [1:0] g0,
    input  logic [1:0] g1,
    input  logic [1:0] g2,
    input  logic [1:0] g3,
    input  logic [1:0] g4,
    input  logic [1:0] g5,
    input  logic [1:0] g6,
    input  logic [1:0] g7,
    input  logic [1:0] g8,
    input  logic [1:0] mark,
    output logic       hit
);

    logic [1:0] cells [9];

    assign cells[0] = g0;
    assign cells[1] = g1;
    assign cells[2] = g2;
    assign cells[3] = g3;
    assign cells[4] = g4;
    assign cells[5] = g5;
    assign cells[6] = g6;
    assign cells[7] = g7;
    assign cells[8] = g8;

    always_comb begin
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (mark != MARK_NONE &&
                cells[WIN_LINES[l][0]] == mark &&
                cells[WIN_LINES[l][1]] == mark &&
                cells[WIN_LINES[l][2]] == mark)
                hit = 1'b1;
        end
    end

endmodule

// File: rtl/move_issuer.sv
// Turn controller: moves a cursor, issues one-cycle marks to the recorder, waits for
// the registered grid to settle, then checks whether the mover completed a line.
//
// state  | meaning
// IDLE   | waiting for start
// PLAY   | cursor moves, confirm accepted on empty cell, optional turn timeout
// ISSUE  | mark driven for exactly one cycle
// SETTLE | waiting for recorder grid to update
// CHECK  | evaluate mover's lines; win -> OVER, else next turn
// OVER   | winner held until rst
module move_issuer
    import game_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic [1:0] g0,
    input  logic [1:0] g1,
    input  logic [1:0] g2,
    input  logic [1:0] g3,
    input  logic [1:0] g4,
    input  logic [1:0] g5,
    input  logic [1:0] g6,
    input  logic [1:0] g7,
    input  logic [1:0] g8,
    output logic [1:0] game_state,
    output logic       whosTurn,
    output logic [1:0] mark,
    output logic [3:0] position,
    output logic [3:0] cursor,
    output logic [1:0] winner,
    output logic       reject
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]    state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [1:0]    grid [9];
    logic [1:0]    mover_mark;
    logic          accept;
    logic          hit;

    assign grid[0] = g0;
    assign grid[1] = g1;
    assign grid[2] = g2;
    assign grid[3] = g3;
    assign grid[4] = g4;
    assign grid[5] = g5;
    assign grid[6] = g6;
    assign grid[7] = g7;
    assign grid[8] = g8;

    assign mover_mark = whosTurn ? MARK_X : MARK_O;
    assign accept     = btn_confirm && (grid[cursor] == MARK_NONE);
    assign mark       = (state == S_ISSUE) ? mover_mark : MARK_NONE;

    line_checker u_line_checker (
        .g0  (g0),
        .g1  (g1),
        .g2  (g2),
        .g3  (g3),
        .g4  (g4),
        .g5  (g5),
        .g6  (g6),
        .g7  (g7),
        .g8  (g8),
        .mark(mover_mark),
        .hit (hit)
    );

    always_comb begin
        game_state = GS_IDLE;
        case (state)
            S_IDLE:                     game_state = GS_IDLE;
            S_PLAY:                     game_state = GS_PLAY;
            S_ISSUE, S_SETTLE, S_CHECK: game_state = GS_BUSY;
            S_OVER:                     game_state = GS_OVER;
            default:                    game_state = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            whosTurn    <= 1'b1;
            position    <= 4'd0;
            cursor      <= 4'd4;
            winner      <= MARK_NONE;
            reject      <= 1'b0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            reject <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_PLAY;
                end
                S_PLAY: begin
                    if (btn_confirm) begin
                        if (accept) begin
                            position <= cursor;
                            state    <= S_ISSUE;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (btn_right && !btn_left) begin
                        cursor <= (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
                    end else if (btn_left && !btn_right) begin
                        cursor <= (cursor == 4'd0) ? 4'd8 : cursor - 4'd1;
                    end
                    // A rejected confirm still lets the turn clock run.
                    if (TIMEOUT_CYCLES > 0 && !accept) begin
                        if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            whosTurn    <= ~whosTurn;
                            timeout_cnt <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= S_CHECK;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    if (hit) begin
                        winner <= mover_mark;
                        state  <= S_OVER;
                    end else begin
                        whosTurn    <= ~whosTurn;
                        timeout_cnt <= '0;
                        state       <= S_PLAY;
                    end
                end
                S_OVER: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
